hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard control for the in-order pipeline, replacing the stall-only hazard detector. It tracks in-flight register writes in a shift-register scoreboard, one entry per post-decode stage. It drives the IF/IFID freeze and, in forwarding mode, per-operand bypass selects for the decode/execute operand muxes. It also keeps a saturating count of stall cycles for performance measurement.

## Interface
- DEPTH, 2: number of tracked post-decode stages; entry 0 = EXE, entry 1 = MEM, …; range 1–6
- REG_W, 5: register address width
- FWD_EN, 1: 0 = stall on any RAW match; 1 = forward, stall only on load-use
- LOAD_STAGE, 1: first entry index from which a load's data is forwardable; must be < DEPTH
- CNT_W, 16: stall counter width
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- id_valid  in  1  decode stage holds a real instruction
- id_src1  in  REG_W  first source register
- id_src2  in  REG_W  second source register
- id_src2_used  in  1  src2 is read; 0 for immediate forms
- id_dest  in  REG_W  destination of the decode instruction
- id_wb_en  in  1  decode instruction writes back
- id_mem_read  in  1  decode instruction is a load
- flush  in  1  branch taken in EXE
- stall  out  1  freeze PC and IFID; insert bubble into IDEXE
- fwd_sel1  out  3  operand-1 source: 0 = register file, k = entry k-1 result
- fwd_sel2  out  3  operand-2 source, same encoding
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard entry fields: valid, dest, wb_en, mem_read.
- Shift every cycle (no hold): entry[i] <= entry[i-1] for i ≥ 1.
- entry[0] <= decode fields when id_valid & !stall & !flush. Otherwise entry[0] <= bubble (valid = 0).
- Match on entry k for source s: valid & wb_en & dest == s & s != 0. Register 0 never matches.
- src2 is ignored when id_src2_used = 0.
- When several entries match, the youngest (lowest k) is used.
- FWD_EN = 0: stall = id_valid & any match on a used source. fwd_sel1 and fwd_sel2 are 0.
- FWD_EN = 1, youngest match k with entry[k].mem_read & k < LOAD_STAGE: stall (load-use). fwd_sel for that operand = 0.
- FWD_EN = 1, any other match: fwd_sel = k+1, no stall for that operand.
- stall = OR over both operands.
- When stall = 1, both fwd_sel outputs are 0.
- flush forces stall = 0: the decode instruction is being killed.
- stall_count increments on each cycle with stall = 1 and holds at 2^CNT_W − 1.
- Upper bits of fwd_sel beyond clog2(DEPTH+1) are 0.

## Timing
- stall and fwd_sel are combinational from current entries and decode inputs, valid in the same cycle.
- Entries and stall_count update on the rising clock edge.
- reset low: all entries invalid and stall_count = 0 immediately. Consequently stall = 0 and fwd_sel1 = fwd_sel2 = 0.
- Reset mid-stall releases the stall asynchronously. The bubbles already in flight are discarded.
- Load-use with LOAD_STAGE = 1: 1 stall cycle. The following cycle forwards from entry 1, fwd_sel = 2.
- FWD_EN = 0, dependent directly after producer: DEPTH stall cycles.
- stall & flush in the same cycle: flush wins. Bubble inserted, stall = 0, counter unchanged.
- A decode instruction with dest = 0 is pushed as-is but never matches.

## Test plan
- After reset, push `add r3` and then `sub` reading src1 = r3, FWD_EN = 1. Required: fwd_sel1 = 1, stall = 0. Next cycle with a fresh reader of r3: fwd_sel1 = 2.
- `lw r5`, then `add` reading r5 as src2 with id_src2_used = 1. Required: stall = 1 for exactly 1 cycle, then fwd_sel2 = 2, stall_count = 1.
- Same load-use but id_src2_used = 0. Required: stall = 0, fwd_sel2 = 0.
- FWD_EN = 0, DEPTH = 2: `add r7`, then a reader of r7. Required: stall = 1 for 2 cycles, then fwd_sel1 = 0 and stall_count = 2.
- Producers r4 in entry 0 and r4 in entry 1, reader of r4. Required: fwd_sel1 = 1 (youngest wins). A writer to r0 followed by a reader of r0: no stall, fwd_sel1 = 0.
- Load-use stall with flush asserted in the same cycle. Required: stall = 0 and entry 0 becomes a bubble. Separately, assert reset low during a stall: stall drops immediately and stall_count = 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based RAW hazard control: tracks in-flight writers per post-decode
// stage, drives the front-end freeze, operand bypass selects and a stall counter.
module hazard_scoreboard #(
    parameter int DEPTH      = 2,
    parameter int REG_W      = 5,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_src1,
    input  logic [REG_W-1:0] i_id_src2,
    input  logic             i_id_src2_used,
    input  logic [REG_W-1:0] i_id_dest,
    input  logic             i_id_wb_en,
    input  logic             i_id_mem_read,
    input  logic             i_flush,
    output logic             o_stall,
    output logic [2:0]       o_fwd_sel1,
    output logic [2:0]       o_fwd_sel2,
    output logic [CNT_W-1:0] o_stall_count
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } entry_t;

    entry_t           r_ent [DEPTH];
    logic [CNT_W-1:0] r_stall_count;

    logic       w_hit1, w_hit2, w_ld1, w_ld2;
    logic [2:0] w_k1, w_k2;
    logic       w_blk1, w_blk2, w_stall, w_push;

    function automatic logic f_match(input entry_t e, input logic [REG_W-1:0] s);
        return e.valid && e.wb_en && (e.dest == s) && (s != '0);
    endfunction

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_hit1 = 1'b0;
        w_k1   = '0;
        w_ld1  = 1'b0;
        w_hit2 = 1'b0;
        w_k2   = '0;
        w_ld2  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (f_match(r_ent[k], i_id_src1)) begin
                w_hit1 = 1'b1;
                w_k1   = 3'(k + 1);
                w_ld1  = r_ent[k].mem_read && (k < LOAD_STAGE);
            end
            if (i_id_src2_used && f_match(r_ent[k], i_id_src2)) begin
                w_hit2 = 1'b1;
                w_k2   = 3'(k + 1);
                w_ld2  = r_ent[k].mem_read && (k < LOAD_STAGE);
            end
        end
    end

    // Without forwarding every match blocks; with it only a not-yet-ready load does.
    assign w_blk1  = w_hit1 && ((FWD_EN == 0) || w_ld1);
    assign w_blk2  = w_hit2 && ((FWD_EN == 0) || w_ld2);
    assign w_stall = i_id_valid && (w_blk1 || w_blk2) && !i_flush;
    assign w_push  = i_id_valid && !w_stall && !i_flush;

    assign o_stall       = w_stall;
    assign o_fwd_sel1    = (w_stall || w_blk1) ? 3'd0 : w_k1;
    assign o_fwd_sel2    = (w_stall || w_blk2) ? 3'd0 : w_k2;
    assign o_stall_count = r_stall_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_stall_count <= '0;
        end else begin
            r_ent[0] <= w_push ? {1'b1, i_id_dest, i_id_wb_en, i_id_mem_read} : '0;
            for (int i = 1; i < DEPTH; i++) r_ent[i] <= r_ent[i-1];
            if (w_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding instance and a stall-only instance
// (2-bit counter to reach saturation) share directed stimulus; a distance model checks both.
module tb_hazard_scoreboard;
    localparam int DEPTH = 2;
    localparam int LS    = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v = 1'b0, u = 1'b0, wb = 1'b0, mr = 1'b0, fl = 1'b0;
    logic [4:0] s1 = '0, s2 = '0, d = '0;

    logic        sa, sb;
    logic [2:0]  f1a, f2a, f1b, f2b;
    logic [15:0] cnta;
    logic [1:0]  cntb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(5), .FWD_EN(1), .LOAD_STAGE(LS), .CNT_W(16)) ua (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(v), .i_id_src1(s1), .i_id_src2(s2),
        .i_id_src2_used(u), .i_id_dest(d), .i_id_wb_en(wb), .i_id_mem_read(mr), .i_flush(fl),
        .o_stall(sa), .o_fwd_sel1(f1a), .o_fwd_sel2(f2a), .o_stall_count(cnta));

    hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(5), .FWD_EN(0), .LOAD_STAGE(LS), .CNT_W(2)) ub (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(v), .i_id_src1(s1), .i_id_src2(s2),
        .i_id_src2_used(u), .i_id_dest(d), .i_id_wb_en(wb), .i_id_mem_read(mr), .i_flush(fl),
        .o_stall(sb), .o_fwd_sel1(f1b), .o_fwd_sel2(f2b), .o_stall_count(cntb));

    // Model: per instance, the list of in-flight writers indexed by distance from decode.
    logic       mv [2][DEPTH];
    logic [4:0] md [2][DEPTH];
    logic       mw [2][DEPTH];
    logic       mm [2][DEPTH];
    int         mcnt [2];
    logic       e_st [2];
    logic [2:0] e_s1 [2];
    logic [2:0] e_s2 [2];

    function automatic int youngest(input int inst, input logic [4:0] s);
        int found;
        found = -1;
        if (s == 5'd0) return -1;
        for (int k = 0; k < DEPTH; k++)
            if (found < 0 && mv[inst][k] && mw[inst][k] && md[inst][k] == s) found = k;
        return found;
    endfunction

    function automatic void meval(input int inst, output logic st, output logic [2:0] o1,
                                  output logic [2:0] o2);
        int  k1, k2;
        logic b1, b2;
        k1 = youngest(inst, s1);
        k2 = u ? youngest(inst, s2) : -1;
        if (inst == 1) begin
            b1 = (k1 >= 0);
            b2 = (k2 >= 0);
        end else begin
            b1 = (k1 >= 0) && mm[inst][k1 < 0 ? 0 : k1] && (k1 < LS);
            b2 = (k2 >= 0) && mm[inst][k2 < 0 ? 0 : k2] && (k2 < LS);
        end
        st = v && (b1 || b2) && !fl;
        o1 = (st || b1 || k1 < 0) ? 3'd0 : 3'(k1 + 1);
        o2 = (st || b2 || k2 < 0) ? 3'd0 : 3'(k2 + 1);
    endfunction

    always_comb begin
        e_st[0] = 1'b0; e_s1[0] = '0; e_s2[0] = '0;
        e_st[1] = 1'b0; e_s1[1] = '0; e_s2[1] = '0;
        meval(0, e_st[0], e_s1[0], e_s2[0]);
        meval(1, e_st[1], e_s1[1], e_s2[1]);
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mv[i][k] <= 1'b0; md[i][k] <= '0; mw[i][k] <= 1'b0; mm[i][k] <= 1'b0;
                end
                mcnt[i] <= 0;
            end else begin
                for (int k = 1; k < DEPTH; k++) begin
                    mv[i][k] <= mv[i][k-1]; md[i][k] <= md[i][k-1];
                    mw[i][k] <= mw[i][k-1]; mm[i][k] <= mm[i][k-1];
                end
                mv[i][0] <= v && !e_st[i] && !fl;
                md[i][0] <= d; mw[i][0] <= wb; mm[i][0] <= mr;
                if (e_st[i] && mcnt[i] < (i == 0 ? 65535 : 3)) mcnt[i] <= mcnt[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model stall A", int'(sa), int'(e_st[0]));
        chk("model sel1 A", int'(f1a), int'(e_s1[0]));
        chk("model sel2 A", int'(f2a), int'(e_s2[0]));
        chk("model count A", int'(cnta), mcnt[0]);
        chk("model stall B", int'(sb), int'(e_st[1]));
        chk("model sel1 B", int'(f1b), int'(e_s1[1]));
        chk("model sel2 B", int'(f2b), int'(e_s2[1]));
        chk("model count B", int'(cntb), mcnt[1]);
    end

    task automatic cyc(input logic iv, input logic [4:0] is1, input logic [4:0] is2,
                       input logic iu, input logic [4:0] id, input logic iwb,
                       input logic imr, input logic ifl);
        @(posedge clk);
        #1;
        v = iv; s1 = is1; s2 = is2; u = iu; d = id; wb = iwb; mr = imr; fl = ifl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        v = 0; fl = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall A", int'(sa), 0);
        chk("reset sel1 A", int'(f1a), 0);
        chk("reset sel2 A", int'(f2a), 0);
        chk("reset count A", int'(cnta), 0);
        chk("reset stall B", int'(sb), 0);
        chk("reset count B", int'(cntb), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // add r3, then readers of r3
        cyc(1, 0, 0, 0, 3, 1, 0, 0);
        cyc(1, 3, 0, 0, 8, 1, 0, 0);
        chk("fwd exe sel1", int'(f1a), 1);
        chk("fwd exe stall", int'(sa), 0);
        cyc(1, 3, 0, 0, 9, 1, 0, 0);
        chk("fwd mem sel1", int'(f1a), 2);
        idle(2);

        // stall-only: add r7 then reader of r7
        pulse_reset();
        cyc(1, 0, 0, 0, 7, 1, 0, 0);
        cyc(1, 7, 0, 0, 10, 1, 0, 0);
        chk("nofwd stall c1", int'(sb), 1);
        cyc(1, 7, 0, 0, 10, 1, 0, 0);
        chk("nofwd stall c2", int'(sb), 1);
        cyc(1, 7, 0, 0, 10, 1, 0, 0);
        chk("nofwd stall c3", int'(sb), 0);
        chk("nofwd sel1", int'(f1b), 0);
        chk("nofwd count", int'(cntb), 2);
        idle(2);

        // lw r5, then add reading r5 as src2
        cyc(1, 0, 0, 0, 5, 1, 1, 0);
        cyc(1, 0, 5, 1, 6, 1, 0, 0);
        chk("loaduse stall", int'(sa), 1);
        chk("loaduse sel2", int'(f2a), 0);
        cyc(1, 0, 5, 1, 6, 1, 0, 0);
        chk("loaduse release", int'(sa), 0);
        chk("loaduse fwd sel2", int'(f2a), 2);
        chk("loaduse count", int'(cnta), 1);
        chk("nofwd count sat", int'(cntb), 3);
        idle(2);

        // same load-use with src2 unused
        cyc(1, 0, 0, 0, 5, 1, 1, 0);
        cyc(1, 0, 5, 0, 6, 1, 0, 0);
        chk("unused src2 stall", int'(sa), 0);
        chk("unused src2 sel2", int'(f2a), 0);
        idle(2);

        // two producers of r4: youngest wins
        cyc(1, 0, 0, 0, 4, 1, 0, 0);
        cyc(1, 0, 0, 0, 4, 1, 0, 0);
        cyc(1, 4, 0, 0, 12, 1, 0, 0);
        chk("youngest sel1", int'(f1a), 1);
        idle(2);

        // writer of r0 then reader of r0
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 13, 1, 0, 0);
        chk("r0 stall", int'(sa), 0);
        chk("r0 sel1", int'(f1a), 0);
        idle(2);

        // load-use coinciding with flush
        cyc(1, 0, 0, 0, 5, 1, 1, 0);
        cyc(1, 0, 5, 1, 6, 1, 0, 1);
        chk("flush stall", int'(sa), 0);
        cyc(1, 6, 0, 0, 11, 1, 0, 0);
        chk("flush bubble sel1", int'(f1a), 0);
        chk("flush bubble stall", int'(sa), 0);
        chk("flush count", int'(cnta), 1);
        idle(2);

        // reset asserted during a stall
        cyc(1, 0, 0, 0, 5, 1, 1, 0);
        cyc(1, 0, 5, 1, 6, 1, 0, 0);
        chk("pre-reset stall", int'(sa), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset stall A", int'(sa), 0);
        chk("async reset count A", int'(cnta), 0);
        chk("async reset stall B", int'(sb), 0);
        chk("async reset count B", int'(cntb), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
